// File: rtl/phase_step_timer_if.sv
// phase_step_timer_if: signal bundle between the phase step timer and the
// four-phase step sequencer FSM it drives.
//
// Signals
//   go_raw    asynchronous start request (level; rising edge requests start)
//   pause     synchronous dwell freeze
//   phase     FSM state code read back (000 idle, 001/010/100 active)
//   start     one-cycle start pulse to the FSM
//   step1..3  one-cycle phase-advance pulses to the FSM
//   dwell_cnt current dwell count
//   busy      timer is running or waiting in an active phase
//   err       sticky illegal-phase flag
//
// Modports
//   master  the side that owns go_raw/pause/phase (sequencer / environment)
//   slave   the timer itself
interface phase_step_timer_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic             go_raw;
  logic             pause;
  logic [2:0]       phase;
  logic             start;
  logic             step1;
  logic             step2;
  logic             step3;
  logic [CNT_W-1:0] dwell_cnt;
  logic             busy;
  logic             err;

  modport master (
    output go_raw,
    output pause,
    output phase,
    input  start,
    input  step1,
    input  step2,
    input  step3,
    input  dwell_cnt,
    input  busy,
    input  err
  );

  modport slave (
    input  go_raw,
    input  pause,
    input  phase,
    output start,
    output step1,
    output step2,
    output step3,
    output dwell_cnt,
    output busy,
    output err
  );

endinterface

// File: rtl/phase_step_timer.sv
// phase_step_timer: event source for the four-phase step sequencer.
// Converts an asynchronous go request into a one-cycle start pulse (only while
// the sequencer is idle) and, in each active phase, times a fixed dwell before
// emitting the matching one-cycle step pulse.
//
// Ports
//   clk    clock
//   reset  asynchronous, active-high reset
//   bus    phase_step_timer_if.slave
//            in : go_raw, pause, phase
//            out: start, step1, step2, step3, dwell_cnt, busy, err
//
// Parameters
//   CNT_W  dwell counter width (must match the interface's CNT_W)
//   T1     dwell cycles in phase 001 before step1
//   T2     dwell cycles in phase 010 before step2
//   T3     dwell cycles in phase 100 before step3
//   Each Tn must lie in 1 .. 2**CNT_W-1.
module phase_step_timer #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned T1    = 10,
  parameter int unsigned T2    = 20,
  parameter int unsigned T3    = 5
) (
  input logic                 clk,
  input logic                 reset,
  phase_step_timer_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [2:0] PH_IDLE = 3'b000;
  localparam logic [2:0] PH_1    = 3'b001;
  localparam logic [2:0] PH_2    = 3'b010;
  localparam logic [2:0] PH_3    = 3'b100;

  // Terminal count per phase: the step pulse fires on the edge where the
  // counter already holds Tn-1, giving exactly Tn unpaused dwell edges.
  localparam logic [CNT_W-1:0] LAST1 = CNT_W'(T1 - 1);
  localparam logic [CNT_W-1:0] LAST2 = CNT_W'(T2 - 1);
  localparam logic [CNT_W-1:0] LAST3 = CNT_W'(T3 - 1);

  // ---------------------------------------------------------------------------
  // go_raw synchronizer and rising-edge detect
  // ---------------------------------------------------------------------------
  logic       go_s1_q;
  logic       go_s2_q;
  logic       go_s3_q;
  logic [2:0] fill_q;
  logic       go_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      go_s1_q <= 1'b0;
      go_s2_q <= 1'b0;
      go_s3_q <= 1'b0;
      fill_q  <= 3'b000;
    end else begin
      go_s1_q <= bus.go_raw;
      go_s2_q <= go_s1_q;
      go_s3_q <= go_s2_q;
      fill_q  <= {fill_q[1:0], 1'b1};
    end
  end

  // fill_q[2] marks that go_s3_q holds a real post-reset sample. Without it a
  // go_raw held high through reset would look like a fresh rising edge when
  // the zeroed chain refills.
  assign go_edge = go_s2_q & ~go_s3_q & fill_q[2];

  // ---------------------------------------------------------------------------
  // Phase decode
  // ---------------------------------------------------------------------------
  logic [2:0]       phase_q;
  logic             phase_legal;
  logic             phase_active;
  logic             phase_changed;
  logic [CNT_W-1:0] last_cnt;

  always_comb begin
    phase_legal  = 1'b1;
    phase_active = 1'b1;
    last_cnt     = '0;
    case (bus.phase)
      PH_IDLE: phase_active = 1'b0;
      PH_1:    last_cnt     = LAST1;
      PH_2:    last_cnt     = LAST2;
      PH_3:    last_cnt     = LAST3;
      default: begin
        phase_legal  = 1'b0;
        phase_active = 1'b0;
      end
    endcase
  end

  assign phase_changed = (bus.phase != phase_q);

  // ---------------------------------------------------------------------------
  // Control FSM and dwell counter
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             start_q;
  logic             start_d;
  logic [2:0]       step_q;
  logic [2:0]       step_d;
  logic             err_q;
  logic             err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = 3'b000;
    err_d   = err_q | ~phase_legal;
    // start can never coincide with a step: it needs phase 000, steps need an
    // active phase.
    start_d = go_edge & (bus.phase == PH_IDLE);

    if (!phase_legal) begin
      state_d = S_ERR;
      if (phase_changed) begin
        cnt_d = '0;
      end
    end else if (phase_changed) begin
      // A phase change restarts the dwell and pre-empts a same-cycle match.
      cnt_d   = '0;
      state_d = phase_active ? S_RUN : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: cnt_d = '0;
        S_RUN: begin
          if (!bus.pause && phase_active) begin
            if (cnt_q == last_cnt) begin
              // Phase codes are one-hot, so the code itself selects stepN.
              step_d  = bus.phase;
              state_d = S_WAIT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: ;  // S_WAIT and S_ERR hold until the next phase change
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      step_q  <= 3'b000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= bus.phase;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.start     = start_q;
  assign bus.step1     = step_q[0];
  assign bus.step2     = step_q[1];
  assign bus.step3     = step_q[2];
  assign bus.dwell_cnt = cnt_q;
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_WAIT);
  assign bus.err       = err_q;

`ifndef SYNTHESIS
  pulses_exclusive: assert property (@(posedge clk) disable iff (reset)
    $onehot0({start_q, step_q}));
  err_sticky: assert property (@(posedge clk) disable iff (reset)
    err_q |=> err_q);
`endif

endmodule

// File: tb/tb_phase_step_timer.sv
// Self-checking bench for phase_step_timer. A behavioural model tracks, per
// clock edge, the go_raw sample history, the number of unpaused dwell edges
// spent in the current phase and the sticky error, and every test compares the
// DUT outputs against it as well as against directed expectations.
module tb_phase_step_timer;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned T1    = 4;
  localparam int unsigned T2    = 20;
  localparam int unsigned T3    = 5;

  logic       clk;
  logic       reset;
  logic       go_r;
  logic       pause_r;
  logic [2:0] phase_r;

  phase_step_timer_if #(.CNT_W(CNT_W)) bus ();

  assign bus.go_raw = go_r;
  assign bus.pause  = pause_r;
  assign bus.phase  = phase_r;

  phase_step_timer #(
    .CNT_W (CNT_W),
    .T1    (T1),
    .T2    (T2),
    .T3    (T3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit               g[$];      // go_raw samples since reset, one per edge
  logic [2:0]       m_prev;
  int               m_n;       // unpaused dwell edges in the current phase
  int               m_t;
  logic             m_start;
  logic [2:0]       m_step;
  logic             m_busy;
  logic             m_err;
  logic [CNT_W-1:0] m_cnt;

  logic [CNT_W+5:0] obs_v;
  logic [CNT_W+5:0] exp_v;
  assign obs_v = {bus.start, bus.step3, bus.step2, bus.step1, bus.busy, bus.err, bus.dwell_cnt};
  assign exp_v = {m_start, m_step[2], m_step[1], m_step[0], m_busy, m_err, m_cnt};

  function automatic int t_of(input logic [2:0] p);
    case (p)
      3'b001:  return T1;
      3'b010:  return T2;
      3'b100:  return T3;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    g.delete();
    m_prev  = 3'b000;
    m_n     = 0;
    m_t     = 0;
    m_start = 1'b0;
    m_step  = 3'b000;
    m_busy  = 1'b0;
    m_err   = 1'b0;
    m_cnt   = '0;
  endtask

  task automatic model_edge();
    bit legal;
    int k;
    legal = phase_r inside {3'b000, 3'b001, 3'b010, 3'b100};
    g.push_back(go_r);
    k = g.size() - 1;
    // A go rising edge sampled at edge E shows as start after edge E+2.
    m_start = (k >= 3) && g[k-2] && !g[k-3] && (phase_r == 3'b000);
    m_step  = 3'b000;
    if (phase_r != m_prev) begin
      m_n = 0;
    end else if (legal && phase_r != 3'b000 && !pause_r && m_n < t_of(phase_r)) begin
      m_n++;
      if (m_n == t_of(phase_r)) m_step = phase_r;
    end
    m_t = t_of(phase_r);
    if (m_n == 0)        m_cnt = '0;
    else if (m_n >= m_t) m_cnt = CNT_W'(m_t - 1);
    else                 m_cnt = CNT_W'(m_n);
    if (!legal) m_err = 1'b1;
    m_busy = legal && (phase_r != 3'b000);
    m_prev = phase_r;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=%h", obs_v, exp_v);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_err got=%b%b want=00", bus.busy, bus.err);
    end
    reset = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL reset_idle got=%h want=%h", obs_v, exp_v);
      end
    end
  endtask

  task automatic test_start();
    int start_at = -1;
    int nstart   = 0;
    phase_r = 3'b000;
    go_r    = 1'b0;
    tick();
    go_r = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL start_model cyc=%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (bus.start === 1'b1) begin
        nstart++;
        if (start_at < 0) start_at = i;
      end
    end
    checks++;
    if (start_at !== 2) begin
      errors++;
      $display("FAIL start_latency got=%0d want=2", start_at);
    end
    checks++;
    if (nstart !== 1) begin
      errors++;
      $display("FAIL start_once got=%0d want=1", nstart);
    end
    go_r = 1'b0;
    tick();
  endtask

  task automatic test_blocked_start();
    int nstart = 0;
    phase_r = 3'b010;
    go_r    = 1'b0;
    repeat (2) tick();
    go_r = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL blocked_model cyc=%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (bus.start === 1'b1) nstart++;
    end
    checks++;
    if (nstart !== 0) begin
      errors++;
      $display("FAIL blocked_start got=%0d want=0", nstart);
    end
    go_r = 1'b0;
  endtask

  task automatic test_dwell();
    int step_at = -1;
    int nstep   = 0;
    phase_r = 3'b000;
    repeat (2) tick();
    phase_r = 3'b001;
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL dwell_model cyc=%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (i <= 3) begin
        checks++;
        if (bus.dwell_cnt !== CNT_W'(i)) begin
          errors++;
          $display("FAIL dwell_count cyc=%0d got=%0d want=%0d", i, bus.dwell_cnt, i);
        end
      end
      if (bus.step1 === 1'b1) begin
        nstep++;
        if (step_at < 0) step_at = i;
      end
    end
    checks++;
    if (step_at !== 4 || nstep !== 1) begin
      errors++;
      $display("FAIL dwell_step1 got=at%0d/x%0d want=at4/x1", step_at, nstep);
    end
  endtask

  task automatic test_pause();
    int step_at = -1;
    phase_r = 3'b010;
    for (int i = 0; i < 35; i++) begin
      pause_r = (i >= 5 && i <= 11);
      tick();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL pause_model cyc=%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (bus.step2 === 1'b1 && step_at < 0) step_at = i;
    end
    pause_r = 1'b0;
    checks++;
    if (step_at !== 27) begin
      errors++;
      $display("FAIL pause_step2 got=%0d want=27", step_at);
    end
  endtask

  task automatic test_change_at_match();
    phase_r = 3'b100;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bus.dwell_cnt !== CNT_W'(4)) begin
      errors++;
      $display("FAIL match_setup got=%0d want=4", bus.dwell_cnt);
    end
    phase_r = 3'b001;
    tick();
    checks++;
    if (bus.step3 !== 1'b0 || bus.dwell_cnt !== '0) begin
      errors++;
      $display("FAIL match_preempt got=step3 %b cnt %0d want=step3 0 cnt 0",
               bus.step3, bus.dwell_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL match_model cyc=%0d got=%h want=%h", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_error();
    int npulse = 0;
    phase_r = 3'b011;
    for (int i = 0; i < 6; i++) begin
      go_r = i[0];
      tick();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL err_model cyc=%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if ({bus.start, bus.step1, bus.step2, bus.step3} !== 4'b0000) npulse++;
    end
    go_r = 1'b0;
    checks++;
    if (bus.err !== 1'b1 || npulse !== 0) begin
      errors++;
      $display("FAIL err_set got=err %b pulses %0d want=err 1 pulses 0", bus.err, npulse);
    end
    phase_r = 3'b001;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL err_recover cyc=%0d got=%h want=%h", i, obs_v, exp_v);
      end
    end
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got=%b want=1", bus.err);
    end
  endtask

  task automatic test_reset_mid();
    bit reached = 1'b0;
    int nstart  = 0;
    apply_reset();
    phase_r = 3'b010;
    go_r    = 1'b1;
    for (int i = 0; i < 15 && !reached; i++) begin
      tick();
      if (bus.dwell_cnt === CNT_W'(7)) reached = 1'b1;
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL midreset_reach got=%0d want=7", bus.dwell_cnt);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs_v !== '0) begin
      errors++;
      $display("FAIL midreset_async got=%h want=0", obs_v);
    end
    @(negedge clk);
    phase_r = 3'b000;
    reset   = 1'b0;
    // go_raw stayed high across reset: no start without a new rising edge.
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL midreset_model cyc=%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (bus.start === 1'b1) nstart++;
    end
    checks++;
    if (nstart !== 0) begin
      errors++;
      $display("FAIL midreset_nostart got=%0d want=0", nstart);
    end
    go_r = 1'b0;
    repeat (3) tick();
    go_r = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.start === 1'b1) nstart++;
    end
    checks++;
    if (nstart !== 1) begin
      errors++;
      $display("FAIL midreset_fresh got=%0d want=1", nstart);
    end
    go_r = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0] legal_codes[4] = '{3'b000, 3'b001, 3'b010, 3'b100};
    logic [2:0] bad_codes[4]   = '{3'b011, 3'b101, 3'b110, 3'b111};
    apply_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 499) == 0) apply_reset();
      if ($urandom_range(0, 11) == 0) begin
        if ($urandom_range(0, 7) == 0) phase_r = bad_codes[$urandom_range(0, 3)];
        else                           phase_r = legal_codes[$urandom_range(0, 3)];
      end
      pause_r = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) go_r = ~go_r;
      tick();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL random cyc=%0d ph=%b got=%h want=%h", i, phase_r, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    go_r    = 1'b0;
    pause_r = 1'b0;
    phase_r = 3'b000;
    reset   = 1'b1;
    model_reset();
    test_reset();
    test_start();
    test_blocked_start();
    test_dwell();
    test_pause();
    test_change_at_match();
    test_error();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
